// File: rtl/uio_bus_arbiter_pkg.sv
// Shared types and constants for the uio pad-bus arbiter and its helpers.
package uio_bus_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_TURN = 2'd1;
  localparam state_t ST_OWN  = 2'd2;

  localparam int HOLD_W = 4;
  localparam int TURN_W = 2;

  localparam logic [7:0] OE_DEFAULT = 8'hFF;

endpackage

// File: rtl/uio_bus_arbiter_if.sv
// Requester/pad bundle of the uio arbiter; master is the requester and pad side.
interface uio_bus_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req;
  logic [N-1:0]   wr;
  logic [8*N-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [7:0]     uio_out;
  logic [7:0]     uio_oe;
  logic [7:0]     uio_in;
  logic [7:0]     rdata;
  logic           rvalid;

  modport master (
    output req, wr, wdata, uio_in,
    input  gnt, uio_out, uio_oe, rdata, rvalid
  );

  modport slave (
    input  req, wr, wdata, uio_in,
    output gnt, uio_out, uio_oe, rdata, rvalid
  );
endinterface

// File: rtl/uio_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module uio_bus_arbiter_rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 valid_o,
  output logic [$clog2(N)-1:0] idx_o
);

  // Scan farthest-first so the candidate closest to the pointer is written last.
  always_comb begin
    int cand;
    cand    = 0;
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = int'(ptr_i) + i;
      if (cand >= N) cand = cand - N;
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = $clog2(N)'(cand);
      end
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin time-sharing of the 8-bit uio pad bus with bounded tenures
// and an all-inputs turnaround gap between owners.
module uio_bus_arbiter
  import uio_bus_arbiter_pkg::*;
#(
  parameter int         N           = 4,
  parameter int         MAX_HOLD    = 8,
  parameter int         TURN_CYCLES = 1,
  parameter logic [7:0] OE_MASK     = OE_DEFAULT
) (
  input logic              clk,
  input logic              rst_n,
  input logic              ena,
  uio_bus_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(N);

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  owner_q, owner_d, ptr_q, ptr_d;
  logic [PTR_W-1:0]  owner_inc, pick_ptr, pick_idx;
  logic              owner_wr_q, owner_wr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic [N-1:0]      gnt_q, gnt_d, owner_mask;
  logic [7:0]        uio_out_q, uio_out_d, uio_oe_q, uio_oe_d, rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              pick_valid, others_pending, arbitrate;

  assign owner_inc = (int'(owner_q) == N - 1) ? '0 : owner_q + 1'b1;
  // On exit from OWN the next owner is searched from just past the current one.
  assign pick_ptr  = (state_q == ST_OWN) ? owner_inc : ptr_q;

  always_comb begin
    owner_mask          = '0;
    owner_mask[owner_q] = 1'b1;
  end

  assign others_pending = |(bus.req & ~owner_mask);

  uio_bus_arbiter_rr_picker #(.N(N)) u_picker (
    .req_i   (bus.req),
    .ptr_i   (pick_ptr),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    // NOTE: every _d gets its default first so no path through the case infers a latch.
    state_d    = state_q;
    owner_d    = owner_q;
    owner_wr_d = owner_wr_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    turn_d     = turn_q;
    arbitrate  = 1'b0;

    case (state_q)
      ST_IDLE: arbitrate = pick_valid;
      ST_TURN: begin
        if (int'(turn_q) + 1 >= TURN_CYCLES) begin
          state_d = ST_OWN;
          hold_d  = HOLD_W'(1);
        end else begin
          turn_d = turn_q + 1'b1;
        end
      end
      ST_OWN: begin
        if (!bus.req[owner_q] || (int'(hold_q) == MAX_HOLD && others_pending)) begin
          ptr_d     = owner_inc;
          hold_d    = '0;
          state_d   = ST_IDLE;
          arbitrate = others_pending;
        end else if (int'(hold_q) < MAX_HOLD) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (arbitrate) begin
      owner_d    = pick_idx;
      owner_wr_d = bus.wr[pick_idx];
      turn_d     = '0;
      if (TURN_CYCLES == 0) begin
        state_d = ST_OWN;
        hold_d  = HOLD_W'(1);
      end else begin
        state_d = ST_TURN;
      end
    end

    // Disable abandons the tenure but keeps the fairness pointer where it was.
    if (!ena) begin
      state_d = ST_IDLE;
      ptr_d   = ptr_q;
      hold_d  = '0;
      turn_d  = '0;
    end
  end

  always_comb begin
    gnt_d     = '0;
    uio_oe_d  = '0;
    uio_out_d = '0;
    if (state_d == ST_OWN) begin
      gnt_d[owner_d] = 1'b1;
      if (owner_wr_d) begin
        uio_oe_d  = OE_MASK;
        uio_out_d = bus.wdata[int'(owner_d)*8 +: 8];
      end
    end
    rvalid_d = ena && (state_q == ST_OWN) && !owner_wr_q;
    rdata_d  = rvalid_d ? bus.uio_in : rdata_q;
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      owner_wr_q <= 1'b0;
      ptr_q      <= '0;
      hold_q     <= '0;
      turn_q     <= '0;
      gnt_q      <= '0;
      uio_out_q  <= '0;
      uio_oe_q   <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_wr_q <= owner_wr_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      turn_q     <= turn_d;
      gnt_q      <= gnt_d;
      uio_out_q  <= uio_out_d;
      uio_oe_q   <= uio_oe_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.uio_out = uio_out_q;
  assign bus.uio_oe  = uio_oe_q;
  assign bus.rdata   = rdata_q;
  assign bus.rvalid  = rvalid_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter (N=4, MAX_HOLD=8, TURN_CYCLES=1, OE_MASK=FF).
module tb_uio_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] wd [4];
  logic       found;
  logic       gap_seen;
  int         checks   = 0;
  int         failures = 0;

  uio_bus_arbiter_if #(.N(4)) bus ();

  uio_bus_arbiter #(
    .N           (4),
    .MAX_HOLD    (8),
    .TURN_CYCLES (1),
    .OE_MASK     (8'hFF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_bus(input string tag, input logic [3:0] g, input logic [7:0] oe,
                            input logic [7:0] out);
    check({tag, ".gnt"},     32'(bus.gnt),     32'(g));
    check({tag, ".uio_oe"},  32'(bus.uio_oe),  32'(oe));
    check({tag, ".uio_out"}, 32'(bus.uio_out), 32'(out));
  endtask

  task automatic expect_rd(input string tag, input logic v, input logic [7:0] d);
    check({tag, ".rvalid"}, 32'(bus.rvalid), 32'(v));
    check({tag, ".rdata"},  32'(bus.rdata),  32'(d));
  endtask

  // Outputs are sampled on the falling edge, half a cycle after they update.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    ena        = 1'b1;
    bus.req    = 4'b0000;
    bus.wr     = 4'b0000;
    bus.uio_in = 8'h00;
    wd[0] = 8'hA5; wd[1] = 8'h2E; wd[2] = 8'h3B; wd[3] = 8'h4D;
    bus.wdata  = {wd[3], wd[2], wd[1], wd[0]};
    repeat (2) tick();
    expect_bus("reset", 4'b0000, 8'h00, 8'h00);
    expect_rd("reset", 1'b0, 8'h00);

    // Single writer: one turnaround cycle, then the grant.
    rst_n   = 1'b1;
    bus.req = 4'b0001;
    bus.wr  = 4'b0001;
    tick(); expect_bus("t1.turn", 4'b0000, 8'h00, 8'h00);
    tick(); expect_bus("t1.own", 4'b0001, 8'hFF, 8'hA5);
    bus.req = 4'b0000;
    tick(); expect_bus("t1.release", 4'b0000, 8'h00, 8'h00);

    // Four writers contending from a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    bus.req = 4'b1111;
    bus.wr  = 4'b1111;
    tick(); expect_bus("t2.turn", 4'b0000, 8'h00, 8'h00);
    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        expect_bus($sformatf("t2.own%0d", t), 4'(1 << (t % 4)), 8'hFF, wd[t % 4]);
      end
      tick(); expect_bus($sformatf("t2.gap%0d", t), 4'b0000, 8'h00, 8'h00);
    end
    // Owner 1 is already committed in TURN, so it gets one cycle despite dropping req.
    bus.req = 4'b0000;
    tick(); expect_bus("t2.committed", 4'b0010, 8'hFF, wd[1]);
    tick(); expect_bus("t2.idle", 4'b0000, 8'h00, 8'h00);

    // Reader on requester 2 (pointer now 2).
    bus.req    = 4'b0100;
    bus.wr     = 4'b0000;
    bus.uio_in = 8'h3C;
    tick(); expect_bus("t3.turn", 4'b0000, 8'h00, 8'h00); expect_rd("t3.turn", 1'b0, 8'h00);
    tick(); expect_bus("t3.own0", 4'b0100, 8'h00, 8'h00); expect_rd("t3.own0", 1'b0, 8'h00);
    tick(); expect_bus("t3.own1", 4'b0100, 8'h00, 8'h00); expect_rd("t3.own1", 1'b1, 8'h3C);
    bus.uio_in = 8'h5A;
    tick(); expect_bus("t3.own2", 4'b0100, 8'h00, 8'h00); expect_rd("t3.own2", 1'b1, 8'h5A);
    bus.req = 4'b0000;
    tick(); expect_bus("t3.rel", 4'b0000, 8'h00, 8'h00); expect_rd("t3.rel", 1'b1, 8'h5A);
    tick(); check("t3.after.rvalid", 32'(bus.rvalid), 32'd0);

    // Lone writer on requester 1 is never preempted.
    bus.req    = 4'b0010;
    bus.wr     = 4'b0010;
    bus.uio_in = 8'h77;
    tick(); expect_bus("t4.turn", 4'b0000, 8'h00, 8'h00);
    for (int c = 0; c < 40; c++) begin
      tick(); expect_bus("t4.lone", 4'b0010, 8'hFF, wd[1]);
    end
    bus.req  = 4'b1010;
    found    = 1'b0;
    gap_seen = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (bus.gnt == 4'b1000) found = 1'b1;
      else if (bus.gnt == 4'b0000) gap_seen = 1'b1;
    end
    check("t4.preempt", 32'(found), 32'd1);
    check("t4.gap", 32'(gap_seen), 32'd1);

    // Requester 3 reads; drop ena mid-tenure, then re-enable (pointer stays 2).
    tick(); expect_bus("t5.own", 4'b1000, 8'h00, 8'h00); expect_rd("t5.own", 1'b1, 8'h77);
    ena = 1'b0;
    tick(); expect_bus("t5.off0", 4'b0000, 8'h00, 8'h00);
    check("t5.off0.rvalid", 32'(bus.rvalid), 32'd0);
    tick(); expect_bus("t5.off1", 4'b0000, 8'h00, 8'h00);
    ena = 1'b1;
    tick(); expect_bus("t5.turn", 4'b0000, 8'h00, 8'h00);
    tick(); expect_bus("t5.regrant", 4'b1000, 8'h00, 8'h00);

    // Direction change mid-tenure is ignored; then reset mid-OWN.
    bus.wr  = 4'b1111;
    bus.req = 4'b1111;
    tick(); expect_bus("t6.wr_ignored", 4'b1000, 8'h00, 8'h00);
    expect_rd("t6.wr_ignored", 1'b1, 8'h77);
    rst_n = 1'b0;
    tick(); expect_bus("t6.reset", 4'b0000, 8'h00, 8'h00); expect_rd("t6.reset", 1'b0, 8'h00);
    rst_n = 1'b1;
    tick(); expect_bus("t6.turn", 4'b0000, 8'h00, 8'h00);
    tick(); expect_bus("t6.first", 4'b0001, 8'hFF, 8'hA5);
    bus.req = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uio_bus_arbiter.md
Name: uio_bus_arbiter

Overview:
- Time-shares the 8-bit bidirectional uio pad bus of the user project between N internal requesters.
- Grants are round-robin; each tenure is bounded.
- A turnaround gap, with all output enables off, is inserted between owners so pad drivers never fight.
- Sits directly under the top-level user project. It drives uio_out/uio_oe and returns registered uio_in data to the current owner.

Parameters:
N, 4, number of requesters (2..8)
MAX_HOLD, 8, max OWN cycles per tenure while another requester is waiting (1..15)
TURN_CYCLES, 1, length of the all-inputs gap before each tenure (0..3)
OE_MASK, 8'hFF, uio bits driven when a write-owner holds the bus

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
ena  in  1  design-selected enable; low forces the bus idle
req  in  N  per-requester bus request (level, held while bus is wanted)
wr  in  N  per-requester direction: 1=drive pads, 0=read pads; sampled at grant
wdata  in  8*N  per-requester output byte, requester i at bits [8i+7:8i]
gnt  out  N  one-hot grant; high only in OWN
uio_out  out  8  pad output data
uio_oe  out  8  pad output enable (1=output)
uio_in  in  8  pad input data
rdata  out  8  registered uio_in for the read-owner
rvalid  out  1  rdata valid, one cycle after a read-OWN cycle

Behaviour:
- All outputs registered. Reset (rst_n=0 at clk edge): state=IDLE, gnt=0, uio_out=0, uio_oe=0, rdata=0, rvalid=0, rr pointer=0, hold counter=0.
- States: IDLE, TURN, OWN.
- IDLE: uio_oe=0, gnt=0.
  - On any req with ena=1: select the first set req at or after the pointer (wrapping).
  - Latch owner index and wr[owner].
  - Go to TURN, or directly to OWN when TURN_CYCLES=0. Decision to first gnt = 1+TURN_CYCLES cycles.
- TURN: uio_oe=0, gnt=0; counts TURN_CYCLES, then OWN. The owner is committed: dropping req during TURN still yields one OWN cycle, then exit.
- OWN:
  - gnt[owner]=1; hold counter increments each cycle.
  - Write-owner: uio_oe=OE_MASK, uio_out=wdata[owner].
  - Read-owner: uio_oe=0, uio_out=0. rdata<=uio_in each cycle; rvalid=1 on the cycle after each read-OWN cycle.
- Exit OWN at the end of a cycle when either:
  - req[owner]=0, or
  - hold counter = MAX_HOLD and some other req is set.
- A lone requester is never preempted: its hold counter saturates and it keeps the bus.
- On exit:
  - pointer <= owner+1 mod N; hold counter <= 0; gnt and uio_oe drop on the next cycle.
  - If other requests are pending, re-arbitrate immediately into TURN (no IDLE cycle); else go to IDLE.
- wr changes after grant are ignored until the next tenure.
- ena=0 sampled at any clock edge: next cycle state=IDLE, gnt=0, uio_oe=0, rvalid=0. Pointer is preserved and in-flight tenures are abandoned.
- Simultaneous requests: exactly one grant, chosen by the pointer. gnt is never multi-hot, and uio_oe≠0 only while gnt≠0 and the owner is a writer.
- Reset mid-tenure: same as the reset values above on the next edge.

Decomposition:
- Shared package holds:
  - state enum (IDLE/TURN/OWN);
  - localparams for the hold-counter width (4b) and turn-counter width (2b);
  - the OE default constant.
- One sub-module is natural: rr_picker. It is combinational and takes req[N], pointer, and returns valid + index. It is reused by other arbiters in the design.

Test Plan:
- Reset, then req=4'b0001, wr=1, wdata0=8'hA5, TURN_CYCLES=1 -> gnt=0001 on the 2nd cycle after req; uio_oe=FF, uio_out=A5; all zero before then.
- req=4'b1111 held, all writers, MAX_HOLD=8 -> grants rotate 0,1,2,3,0; each tenure is 8 gnt cycles followed by 1 cycle of gnt=0, uio_oe=0.
- Requester 2 reads (wr=0), uio_in=8'h3C -> uio_oe=0 throughout; rdata=3C with rvalid=1 one cycle after each OWN cycle; rvalid=0 after release.
- Lone req[1] held 40 cycles -> gnt=0010 continuously with no preemption. Then raise req[3] -> preemption within MAX_HOLD cycles, and gnt=1000 after the turnaround.
- ena dropped mid-OWN -> next cycle gnt=0, uio_oe=0, rvalid=0. Re-raise ena -> arbitration restarts from the preserved pointer.
- rst_n=0 for one edge mid-OWN -> all outputs 0 next cycle; the first grant after reset goes to the lowest-index requester.
